// File: rtl/i2c_target_if.sv
// rtl/i2c_target_if.sv - pin and register-window signals of the I2C target
interface i2c_target_if #(
  parameter int REG_BITS = 4
);
  logic                scl_in;
  logic                sda_in;
  logic                sda_oe;
  logic                busy;
  logic [REG_BITS-1:0] reg_addr;
  logic [7:0]          reg_wdata;
  logic                reg_we;
  logic [7:0]          reg_rdata;
  logic                reg_re;

  modport slave (
    input  scl_in, sda_in, reg_rdata,
    output sda_oe, busy, reg_addr, reg_wdata, reg_we, reg_re
  );

  modport master (
    output scl_in, sda_in, reg_rdata,
    input  sda_oe, busy, reg_addr, reg_wdata, reg_we, reg_re
  );
endinterface

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target with an auto-incrementing byte register window
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h48,
  parameter int         REG_BITS = 4
) (
  input  logic         clk,
  input  logic         reset,
  i2c_target_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, WR_PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  localparam logic [REG_BITS-1:0] PTR_ONE = 1;

  state_t              state;
  logic [3:0]          cnt;
  logic [7:0]          shift;
  logic                rw;
  logic [REG_BITS-1:0] ptr;
  logic                oe;
  logic                busy_q;
  logic                we;
  logic [7:0]          wdata;
  logic                re;

  logic scl_s1, scl_s2, scl_h;
  logic sda_s1, sda_s2, sda_h;

  // Two-stage synchroniser plus one history stage; idle bus reads as high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_h  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_h  <= 1'b1;
    end else begin
      scl_s1 <= bus.scl_in;
      scl_s2 <= scl_s1;
      scl_h  <= scl_s2;
      sda_s1 <= bus.sda_in;
      sda_s2 <= sda_s1;
      sda_h  <= sda_s2;
    end
  end

  // START/STOP require SCL steady high, so an SCL edge in the same clk wins.
  logic scl_rise, scl_fall, start_ev, stop_ev;
  assign scl_rise = scl_s2 & ~scl_h;
  assign scl_fall = ~scl_s2 & scl_h;
  assign start_ev = scl_s2 & scl_h & ~sda_s2 & sda_h;
  assign stop_ev  = scl_s2 & scl_h & sda_s2 & ~sda_h;

  // Protocol state machine with all bus and register outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      shift  <= 8'd0;
      rw     <= 1'b0;
      ptr    <= '0;
      oe     <= 1'b0;
      busy_q <= 1'b0;
      we     <= 1'b0;
      wdata  <= 8'd0;
      re     <= 1'b0;
    end else begin
      we <= 1'b0;
      re <= 1'b0;
      // the write strobe shows the old pointer; it advances the clk after
      if (we) ptr <= ptr + PTR_ONE;

      if (start_ev) begin
        state <= ADDR;
        cnt   <= 4'd0;
        oe    <= 1'b0;
      end else if (stop_ev) begin
        state  <= IDLE;
        cnt    <= 4'd0;
        oe     <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift <= {shift[6:0], sda_s2};
              cnt   <= cnt + 4'd1;
            end else if (scl_fall && cnt == 4'd8) begin
              if (shift[7:1] == DEV_ADDR) begin
                oe     <= 1'b1;
                busy_q <= 1'b1;
                rw     <= shift[0];
                state  <= ADDR_ACK;
              end else begin
                busy_q <= 1'b0;
                state  <= IGNORE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                shift <= bus.reg_rdata;
                re    <= 1'b1;
                oe    <= ~bus.reg_rdata[7];
                cnt   <= 4'd1;
                state <= RD_DATA;
              end else begin
                oe    <= 1'b0;
                cnt   <= 4'd0;
                state <= WR_PTR;
              end
            end
          end
          WR_PTR, WR_DATA: begin
            if (scl_rise) begin
              shift <= {shift[6:0], sda_s2};
              cnt   <= cnt + 4'd1;
              if (state == WR_DATA && cnt == 4'd7) begin
                we    <= 1'b1;
                wdata <= {shift[6:0], sda_s2};
              end
            end else if (scl_fall && cnt == 4'd8) begin
              if (state == WR_PTR) ptr <= shift[REG_BITS-1:0];
              oe    <= 1'b1;
              state <= WR_ACK;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              oe    <= 1'b0;
              cnt   <= 4'd0;
              state <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (cnt == 4'd8) begin
                oe    <= 1'b0;
                ptr   <= ptr + PTR_ONE;
                state <= RD_ACK;
              end else begin
                oe    <= ~shift[6];
                shift <= {shift[6:0], 1'b0};
                cnt   <= cnt + 4'd1;
              end
            end
          end
          RD_ACK: begin
            // a fall here always follows an ACKed rise; NACK leaves on the rise
            if (scl_rise) begin
              if (sda_s2) state <= IGNORE;
            end else if (scl_fall) begin
              shift <= bus.reg_rdata;
              re    <= 1'b1;
              oe    <= ~bus.reg_rdata[7];
              cnt   <= 4'd1;
              state <= RD_DATA;
            end
          end
          default: begin
            oe <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.sda_oe    = oe;
  assign bus.busy      = busy_q;
  assign bus.reg_addr  = ptr;
  assign bus.reg_wdata = wdata;
  assign bus.reg_we    = we;
  assign bus.reg_re    = re;

endmodule
